// File: rtl/dsm_pkg.sv
// dsm_pkg: shared sizing helpers for the DSM interpolator slice.
//   osr_of         : oversampling ratio from its log2
//   acc_width      : linear-interpolation accumulator width
//   delta_width    : segment slope width (one bit wider than a sample)
//   tick_cnt_width : width of the CLK_DIV tick counter (at least 1 bit)
package dsm_pkg;

  function automatic int osr_of(input int log2_osr);
    return 1 << log2_osr;
  endfunction

  // Holds x0 << LOG2_OSR plus up to OSR-1 slope steps with a spare sign bit.
  function automatic int acc_width(input int data_width, input int log2_osr);
    return data_width + log2_osr + 1;
  endfunction

  // x1 - x0 of two DATA_WIDTH samples needs one extra bit to never overflow.
  function automatic int delta_width(input int data_width);
    return data_width + 1;
  endfunction

  // clog2(1) is 0; keep a 1-bit counter so the register is never zero-width.
  function automatic int tick_cnt_width(input int clk_div);
    return (clk_div > 1) ? $clog2(clk_div) : 1;
  endfunction

endpackage

// File: rtl/dsm_tick_gen.sv
// dsm_tick_gen: clock-enable divider producing one tick every CLK_DIV cycles.
// Ports: i_clk (clock), i_rst (sync active-high reset), o_tick (registered
// one-cycle strobe, high in the cycle after the counter wraps to 0).
// With CLK_DIV = 1 o_tick is constantly high from the first cycle after reset.
module dsm_tick_gen
  import dsm_pkg::*;
#(
  parameter int CLK_DIV = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  output logic o_tick
);

  localparam int CW = tick_cnt_width(CLK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] r_cnt;
  logic          r_tick;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt == CNT_LAST) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + CW'(1);
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

// File: rtl/dsm_interpolator.sv
// dsm_interpolator: upsamples base-rate PCM to one output per oversampling
// tick, feeding dsm_dac directly (o_data/o_en -> DAC data/enable).
// Ports: i_clk, i_rst (sync active-high); i_valid/i_data/o_ready input
// handshake (one-entry buffer, o_ready registered); o_data valid while o_en;
// o_underrun pulses with o_en when a segment boundary finds no new sample.
// Macro DSM_INTERP_LINEAR_EN: defined -> linear interpolation between
// segment endpoints; undefined -> zero-order hold of the segment start value.
module dsm_interpolator
  import dsm_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LOG2_OSR   = 6,
  parameter int CLK_DIV    = 1
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  input  logic signed [DATA_WIDTH-1:0] i_data,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_data,
  output logic                         o_en,
  output logic                         o_underrun
);

  localparam int OSR = osr_of(LOG2_OSR);
  localparam logic [LOG2_OSR-1:0] PH_LAST = LOG2_OSR'(OSR - 1);

  // Tick generator
  logic w_tick;

  dsm_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_tick (w_tick)
  );

  // State
  logic [DATA_WIDTH-1:0] r_next;
  logic                  r_next_full;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_x0;
  logic [DATA_WIDTH-1:0] r_x1;
  logic [LOG2_OSR-1:0]   r_phase;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_en;
  logic                  r_underrun;

  logic                  w_hs;
  logic                  w_bound;
  logic                  w_next_full_nxt;
  logic [DATA_WIDTH-1:0] w_out;

  assign w_hs    = i_valid & r_ready;
  assign w_bound = w_tick & (r_phase == PH_LAST);

  // A handshake only happens while the buffer is empty, so it never
  // collides with a boundary that drains the buffer.
  always_comb begin
    w_next_full_nxt = r_next_full;
    if (w_hs) begin
      w_next_full_nxt = 1'b1;
    end else if (w_bound) begin
      w_next_full_nxt = 1'b0;
    end
  end

`ifdef DSM_INTERP_LINEAR_EN
  localparam int AW  = acc_width(DATA_WIDTH, LOG2_OSR);
  localparam int DW1 = delta_width(DATA_WIDTH);

  logic [DW1-1:0] w_delta;
  logic [AW-1:0]  w_acc_nxt;
  logic [AW-1:0]  r_acc;

  assign w_delta = {r_x1[DATA_WIDTH-1], r_x1} - {r_x0[DATA_WIDTH-1], r_x0};

  // Phase 0 restarts from x0 scaled by OSR, later phases add one slope step;
  // dropping the low LOG2_OSR bits is an arithmetic shift (floor rounding).
  assign w_acc_nxt = (r_phase == '0)
                   ? {r_x0[DATA_WIDTH-1], r_x0, {LOG2_OSR{1'b0}}}
                   : r_acc + {{LOG2_OSR{w_delta[DW1-1]}}, w_delta};

  assign w_out = w_acc_nxt[LOG2_OSR +: DATA_WIDTH];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc <= '0;
    end else if (w_tick) begin
      r_acc <= w_acc_nxt;
    end
  end
`else
  assign w_out = r_x0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_next      <= '0;
      r_next_full <= 1'b0;
      r_ready     <= 1'b0;
      r_x0        <= '0;
      r_x1        <= '0;
      r_phase     <= '0;
      r_data      <= '0;
      r_en        <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_en        <= w_tick;
      r_underrun  <= w_bound & ~r_next_full;
      r_next_full <= w_next_full_nxt;
      r_ready     <= ~w_next_full_nxt;

      if (w_hs) begin
        r_next <= i_data;
      end

      if (w_tick) begin
        r_data  <= w_out;
        r_phase <= r_phase + LOG2_OSR'(1);  // wraps at OSR
      end

      if (w_bound) begin
        r_x0 <= r_x1;
        if (r_next_full) begin
          r_x1 <= r_next;
        end
      end
    end
  end

  assign o_ready    = r_ready;
  assign o_data     = r_data;
  assign o_en       = r_en;
  assign o_underrun = r_underrun;

endmodule

// File: tb/tb_dsm_interpolator.sv
// tb_dsm_interpolator: directed scoreboard bench for dsm_interpolator.
// Two instances share the clock: DUT1 (CLK_DIV=1) and DUT2 (CLK_DIV=3),
// both DATA_WIDTH=16, LOG2_OSR=2 (OSR=4).
module tb_dsm_interpolator;

  localparam int DW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst1 = 1'b1, vld1 = 1'b0, rdy1, en1, ur1;
  logic signed [DW-1:0] din1 = '0, dout1;
  logic                 rst2 = 1'b1, vld2 = 1'b0, rdy2, en2, ur2;
  logic signed [DW-1:0] din2 = '0, dout2;

  dsm_interpolator #(.DATA_WIDTH(DW), .LOG2_OSR(2), .CLK_DIV(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst1), .i_valid(vld1), .i_data(din1),
    .o_ready(rdy1), .o_data(dout1), .o_en(en1), .o_underrun(ur1)
  );

  dsm_interpolator #(.DATA_WIDTH(DW), .LOG2_OSR(2), .CLK_DIV(3)) u_dut2 (
    .i_clk(clk), .i_rst(rst2), .i_valid(vld2), .i_data(din2),
    .o_ready(rdy2), .o_data(dout2), .o_en(en2), .o_underrun(ur2)
  );

  typedef struct { int data; bit ur; } exp_t;
  exp_t q1[$];
  exp_t q2[$];

  int checks = 0;
  int errors = 0;

  function automatic void check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Push n expected outputs of one segment. Linear values are hand-computed
  // floor(x0 + p*(x1-x0)/4); in hold mode every phase shows x0.
  task automatic push_seg(input int which, input int x0, input int v1, input int v2,
                          input int v3, input bit ur, input int n);
    int v[4];
`ifdef DSM_INTERP_LINEAR_EN
    v = '{x0, v1, v2, v3};
`else
    v = '{x0, x0, x0, x0};
`endif
    for (int p = 0; p < n; p++) begin
      exp_t e;
      e.data = v[p];
      e.ur   = (p == 3) && ur;
      if (which == 1) q1.push_back(e);
      else            q2.push_back(e);
    end
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input int which, input logic signed [DW-1:0] v);
    int n;
    n = 0;
    while (((which == 1) ? rdy1 : rdy2) !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("send ready seen", int'((which == 1) ? rdy1 : rdy2), 1);
    if (which == 1) begin vld1 = 1'b1; din1 = v; end
    else            begin vld2 = 1'b1; din2 = v; end
    @(negedge clk);
    if (which == 1) begin vld1 = 1'b0; din1 = 16'sh7123; end
    else            begin vld2 = 1'b0; din2 = 16'sh7123; end
  endtask

  // Monitors
  bit mon1_on = 1'b0, en1_seen = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (mon1_on) begin
      check("dut1 underrun without o_en", int'(ur1 & ~en1), 0);
      if (en1_seen) check("dut1 o_en steady", int'(en1), 1);
      if (en1) begin
        en1_seen = 1'b1;
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut1 unexpected output: got data %0d, required no output", dout1);
        end else begin
          e = q1.pop_front();
          check("dut1 o_data", int'(dout1), e.data);
          check("dut1 o_underrun", int'(ur1), int'(e.ur));
        end
      end
    end
  end

  bit mon2_on = 1'b0;
  int cyc2 = 0, last_en2 = -1;
  always @(negedge clk) begin
    exp_t e;
    cyc2++;
    if (mon2_on) begin
      check("dut2 underrun without o_en", int'(ur2 & ~en2), 0);
      if (en2) begin
        if (last_en2 >= 0) check("dut2 o_en spacing", cyc2 - last_en2, 3);
        last_en2 = cyc2;
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL dut2 unexpected output: got data %0d, required no output", dout2);
        end else begin
          e = q2.pop_front();
          check("dut2 o_data", int'(dout2), e.data);
          check("dut2 o_underrun", int'(ur2), int'(e.ur));
        end
      end
    end
  end

  // DUT1 expected segments: x0, phase1..3 (linear), boundary underrun.
  int seg_tab [14][5] = '{
    '{     0,      0,      0,      0, 0},  // startup x0=x1=0, 400 buffered
    '{     0,    100,    200,    300, 0},  // ramp 0 -> 400
    '{   400,    400,    400,    400, 0},  // 400 -> 400
    '{   400,    200,      0,   -200, 0},  // negative step 400 -> -400
    '{  -400,   -300,   -200,   -100, 0},  // -400 -> 0
    '{     0,     -1,     -2,     -3, 0},  // floor rounding 0 -> -3
    '{    -3,   8189,  16382,  24574, 0},  // -3 -> 32767
    '{ 32767,  16383,     -1, -16385, 1},  // full-scale swing, no wrap
    '{-32768, -32768, -32768, -32768, 1},  // starved: flat at x1
    '{-32768, -32768, -32768, -32768, 0},  // starved, A buffered meanwhile
    '{-32768, -24576, -16384,  -8192, 0},  // -> A=0
    '{     0,      2,      4,      6, 0},  // -> B=8
    '{     8,      4,      0,     -4, 1},  // -> C=-8, then starved
    '{    -8,     -8,     -8,     -8, 1}   // flat at -8
  };

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int gap;
    logic signed [DW-1:0] held [3];
    held = '{16'sd0, 16'sd8, -16'sd8};

    // DUT1 reset behaviour
    repeat (3) begin
      @(negedge clk);
      check("dut1 reset o_data", int'(dout1), 0);
      check("dut1 reset o_en", int'(en1), 0);
      check("dut1 reset o_underrun", int'(ur1), 0);
      check("dut1 reset o_ready", int'(rdy1), 0);
    end
    for (int s = 0; s < 14; s++)
      push_seg(1, seg_tab[s][0], seg_tab[s][1], seg_tab[s][2], seg_tab[s][3],
               seg_tab[s][4] != 0, 4);
    mon1_on = 1'b1;
    rst1 = 1'b0;
    @(negedge clk);
    check("dut1 o_ready after release", int'(rdy1), 1);
    check("dut1 o_en after release", int'(en1), 0);

    send(1, 16'sd400);
    send(1, 16'sd400);
    send(1, -16'sd400);
    send(1, 16'sd0);
    send(1, -16'sd3);
    send(1, 16'sd32767);
    send(1, -16'sd32768);
    repeat (11) @(negedge clk);  // starve two boundaries

    // Backpressure: i_valid held high across three distinct samples
    vld1 = 1'b1;
    for (int k = 0; k < 3; k++) begin
      din1 = held[k];
      gap = 0;
      while (rdy1 !== 1'b1 && gap < 20) begin
        @(negedge clk);
        gap++;
      end
      check("dut1 ready-low cycles before accept", gap, (k == 0) ? 0 : 3);
      @(negedge clk);
    end
    vld1 = 1'b0;

    n = 0;
    while (q1.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    mon1_on = 1'b0;
    check("dut1 scoreboard drained", q1.size(), 0);

    // DUT2: CLK_DIV=3, reset mid-segment
    repeat (3) begin
      @(negedge clk);
      check("dut2 reset o_data", int'(dout2), 0);
      check("dut2 reset o_en", int'(en2), 0);
      check("dut2 reset o_ready", int'(rdy2), 0);
    end
    push_seg(2, 0, 0, 0, 0, 1'b0, 4);
    push_seg(2, 0, 100, 200, 300, 1'b0, 3);
    mon2_on = 1'b1;
    rst2 = 1'b0;
    @(negedge clk);
    check("dut2 o_ready after release", int'(rdy2), 1);
    send(2, 16'sd400);
    send(2, 16'sd800);
    repeat (8) @(negedge clk);  // phase 2 of second segment just shown
    #1;
    check("dut2 outputs before reset", q2.size(), 0);
    check("dut2 sample buffered before reset", int'(rdy2), 0);
    rst2 = 1'b1;
    last_en2 = -1;
    repeat (3) begin
      @(negedge clk);
      check("dut2 mid reset o_data", int'(dout2), 0);
      check("dut2 mid reset o_en", int'(en2), 0);
      check("dut2 mid reset o_underrun", int'(ur2), 0);
      check("dut2 mid reset o_ready", int'(rdy2), 0);
    end
    // Buffered 800 is lost: both boundaries underrun, output stays 0.
    push_seg(2, 0, 0, 0, 0, 1'b1, 4);
    push_seg(2, 0, 0, 0, 0, 1'b1, 4);
    rst2 = 1'b0;
    @(negedge clk);
    check("dut2 o_ready after mid reset", int'(rdy2), 1);
    n = 0;
    while (q2.size() != 0 && n < 200) begin @(posedge clk); n++; end
    #1;
    mon2_on = 1'b0;
    check("dut2 scoreboard drained", q2.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
